pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage RISC-V core.
- Drives per-register enable and flush controls:
  - Flushes all registers after reset.
  - Inserts load-use bubbles.
  - Squashes wrong-path instructions on a taken branch.
  - Freezes the pipeline while data memory is wait-stated, with a timeout error trap.

Parameters:
- INIT_FLUSH_CYC, 4, cycles after reset during which all pipeline registers are flushed and the PC is held.
- MEM_TIMEOUT, 15, maximum consecutive data-memory wait cycles before the error state (1..255).
- TMO_W, 8, width of the wait counter.

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  synchronous, active-high reset
- id_rs1_i  in  5  rs1 index of instruction in ID
- id_rs2_i  in  5  rs2 index of instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of instruction in EX
- ex_branch_taken_i  in  1  taken branch/jump resolved in EX
- mem_req_i  in  1  MEM stage performs a data access this cycle
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_en_o  out  1  PC update enable
- ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  register load enables
- ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  out  1 each  load bubble (zeros, Reg_W=0) instead of data
- err_o  out  1  sticky memory-timeout error
- state_o  out  2  current FSM state (debug)

Behaviour:
- State register and counters update on posedge clk_i only.
- Outputs are combinational from the current state and inputs, so stall and flush take effect in the same cycle.
- Reset: reset_i=1 at an edge sets state=INIT, init_cnt=0, wait_cnt=0, err_o=0. Reset mid-operation (any state, including ERR) behaves identically.
- States: INIT=0, RUN=1, MEM_WAIT=2, ERR=3.
- INIT:
  - Outputs: pc_en_o=0; all *_en_o=1; all *_flush_o=1.
  - init_cnt increments each cycle.
  - Go to RUN on the cycle init_cnt==INIT_FLUSH_CYC-1.
- RUN, priority high to low:
  - (a) mem_req_i && !mem_ready_i (memory stall):
    - pc_en_o=0; ifid/idex/exmem en=0; memwb_en_o=1 with memwb_flush_o=1 (bubble, prevents a duplicate writeback).
    - Next state MEM_WAIT, wait_cnt=1.
  - (b) ex_branch_taken_i:
    - All enables=1; ifid_flush_o=1; idex_flush_o=1.
    - Load-use is ignored, because the ID instruction is squashed.
  - (c) Load-use: ex_mem_read_i && ex_rd_i!=0 && ((id_uses_rs1_i && id_rs1_i==ex_rd_i) || (id_uses_rs2_i && id_rs2_i==ex_rd_i)):
    - pc_en_o=0; ifid_en_o=0; idex_en_o=1 with idex_flush_o=1; exmem/memwb en=1.
    - Exactly one bubble; the condition clears on its own next cycle.
  - (d) Otherwise: all en=1, all flush=0.
- MEM_WAIT:
  - Outputs as in RUN case (a) while !mem_ready_i.
  - mem_ready_i=1: outputs as RUN with rules (b)-(d) evaluated; next state RUN; wait_cnt=0.
  - A branch or load-use held during the stall is therefore applied on the release cycle.
  - wait_cnt increments while waiting. If wait_cnt==MEM_TIMEOUT and !mem_ready_i, next state ERR.
  - mem_req_i dropping while in MEM_WAIT is treated as ready.
- ERR:
  - pc_en_o=0; all en=0; all flush=0; err_o=1.
  - Left only by reset.
- Widths: wait_cnt saturates at 2^TMO_W-1. A MEM_TIMEOUT of 0 or greater than 2^TMO_W-1 is a configuration error, flagged by a simulation-time assertion.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds ports stall_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0.
  - stall_cnt_o increments each RUN/MEM_WAIT cycle with pc_en_o=0.
  - flush_cnt_o increments each cycle rule (b) fires.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - State encodings (INIT/RUN/MEM_WAIT/ERR).
  - Register-index width constant (5).
  - Bubble constant shared with the pipeline registers.
- One natural sub-module: load_use_detect, the purely combinational rs/rd compare producing the load-use flag.

Test Plan:
- Reset for 2 cycles, then release -> 4 cycles with pc_en_o=0 and all flush=1, state_o=1 on cycle 5, outputs all en=1, flush=0.
- In RUN, ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 -> same cycle pc_en_o=0, ifid_en_o=0, idex_flush_o=1; next cycle (inputs cleared) normal. Repeat with ex_rd_i=0 -> no stall.
- ex_branch_taken_i=1 together with the load-use condition -> ifid_flush_o=1, idex_flush_o=1, pc_en_o=1, no stall.
- mem_req_i=1, mem_ready_i=0 for 3 cycles, then 1 -> 3 cycles freeze with memwb_flush_o=1, state_o=2; release cycle state_o returns 1 next edge, err_o stays 0.
- mem_req_i=1, mem_ready_i stuck 0 -> after 15 wait cycles state_o=3, err_o=1, all en=0. Then reset_i=1 for 1 cycle -> state_o=0, err_o=0.
- HAZARD_PERF_CNT_EN build: one load-use stall, one 3-cycle memory stall, two branch flushes -> stall_cnt_o=4, flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and control bundles shared by the
// pipeline hazard sequencer and the pipeline registers.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ERR      = 2'd3
   } state_e;

   // Reg_W value a flushed pipeline register carries
   localparam logic BUBBLE_REG_W = 1'b0;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_OFF       = 9'b0_0000_0000;
   localparam ctrl_t CTRL_INIT      = 9'b0_1111_1111;
   localparam ctrl_t CTRL_NORMAL    = 9'b1_1111_0000;
   localparam ctrl_t CTRL_BRANCH    = 9'b1_1111_1100;
   localparam ctrl_t CTRL_LOAD_USE  = 9'b0_0111_0100;
   localparam ctrl_t CTRL_MEM_STALL = 9'b0_0001_0001;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination
// of a load still in EX.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic                 ex_mem_read_i,
   input  logic [REG_IDX_W-1:0] ex_rd_i,
   input  logic [REG_IDX_W-1:0] id_rs1_i,
   input  logic [REG_IDX_W-1:0] id_rs2_i,
   input  logic                 id_uses_rs1_i,
   input  logic                 id_uses_rs2_i,
   output logic                 load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
      rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
      // x0 never carries a real dependency
      load_use_o = ex_mem_read_i && (ex_rd_i != '0)
                   && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/pipeline-register enable and flush sequencer.
// Optional HAZARD_PERF_CNT_EN adds stall and flush event counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int INIT_FLUSH_CYC = 4,
   parameter int MEM_TIMEOUT    = 15,
   parameter int TMO_W          = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [REG_IDX_W-1:0] id_rs1_i,
   input  logic [REG_IDX_W-1:0] id_rs2_i,
   input  logic                 id_uses_rs1_i,
   input  logic                 id_uses_rs2_i,
   input  logic                 ex_mem_read_i,
   input  logic [REG_IDX_W-1:0] ex_rd_i,
   input  logic                 ex_branch_taken_i,
   input  logic                 mem_req_i,
   input  logic                 mem_ready_i,
   output logic                 pc_en_o,
   output logic                 ifid_en_o,
   output logic                 idex_en_o,
   output logic                 exmem_en_o,
   output logic                 memwb_en_o,
   output logic                 ifid_flush_o,
   output logic                 idex_flush_o,
   output logic                 exmem_flush_o,
   output logic                 memwb_flush_o,
   output logic                 err_o,
   output logic [1:0]           state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cnt_o,
   output logic [31:0]          flush_cnt_o
`endif
);

   localparam int TMO_MAX = (1 << TMO_W) - 1;
   localparam logic [7:0] INIT_LAST = 8'(INIT_FLUSH_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [7:0]       init_cnt_q, init_cnt_d;
   logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             load_use;
   logic             mem_stall;
   ctrl_t            run_ctrl;
   ctrl_t            ctrl;

   load_use_detect u_lud (
      .ex_mem_read_i (ex_mem_read_i),
      .ex_rd_i       (ex_rd_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .load_use_o    (load_use)
   );

   // A dropped request releases the stall just like a ready
   assign mem_stall = mem_req_i && !mem_ready_i;

   always_comb begin
      if (ex_branch_taken_i)
         run_ctrl = CTRL_BRANCH;
      else if (load_use)
         run_ctrl = CTRL_LOAD_USE;
      else
         run_ctrl = CTRL_NORMAL;
   end

   always_comb begin
      ctrl       = CTRL_OFF;
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         ST_INIT: begin
            ctrl       = CTRL_INIT;
            init_cnt_d = init_cnt_q + 8'd1;
            if (init_cnt_q == INIT_LAST)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (mem_stall) begin
               ctrl       = CTRL_MEM_STALL;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = TMO_W'(1);
            end else begin
               ctrl = run_ctrl;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_stall) begin
               ctrl = CTRL_MEM_STALL;
               if (wait_cnt_q == TMO_LIMIT)
                  state_d = ST_ERR;
               if (wait_cnt_q != {TMO_W{1'b1}})
                  wait_cnt_d = wait_cnt_q + TMO_W'(1);
            end else begin
               ctrl       = run_ctrl;
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         ST_ERR: begin
            ctrl = CTRL_OFF;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      assert (MEM_TIMEOUT >= 1 && MEM_TIMEOUT <= TMO_MAX)
         else $error("MEM_TIMEOUT outside 1..2^TMO_W-1");
   end

   assign pc_en_o       = ctrl.pc_en;
   assign ifid_en_o     = ctrl.ifid_en;
   assign idex_en_o     = ctrl.idex_en;
   assign exmem_en_o    = ctrl.exmem_en;
   assign memwb_en_o    = ctrl.memwb_en;
   assign ifid_flush_o  = ctrl.ifid_flush;
   assign idex_flush_o  = ctrl.idex_flush;
   assign exmem_flush_o = ctrl.exmem_flush;
   assign memwb_flush_o = ctrl.memwb_flush;
   assign err_o         = (state_q == ST_ERR);
   assign state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic        active;

   always_comb begin
      active      = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (active && !ctrl.pc_en)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (active && !mem_stall && ex_branch_taken_i)
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl.
// Define HAZARD_PERF_CNT_EN to also check the event counters.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic       ld;
      logic [4:0] rd;
      logic       u1;
      logic [4:0] rs1;
      logic       u2;
      logic [4:0] rs2;
      logic       br;
      logic       req;
      logic       rdy;
   } stim_t;

   typedef struct packed {
      stim_t       s;
      logic [11:0] x;
   } step_t;

   typedef struct {
      int          k;
      logic [11:0] x;
   } sb_t;

   // {pc, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
   localparam logic [8:0] C_INIT = 9'b0_1111_1111;
   localparam logic [8:0] C_RUN  = 9'b1_1111_0000;
   localparam logic [8:0] C_LU   = 9'b0_0111_0100;
   localparam logic [8:0] C_BR   = 9'b1_1111_1100;
   localparam logic [8:0] C_MEM  = 9'b0_0001_0001;

   localparam logic [11:0] X_INIT = {C_INIT, 1'b0, 2'd0};
   localparam logic [11:0] X_RUN  = {C_RUN, 1'b0, 2'd1};
   localparam logic [11:0] X_LU   = {C_LU, 1'b0, 2'd1};
   localparam logic [11:0] X_BR   = {C_BR, 1'b0, 2'd1};
   localparam logic [11:0] X_MEM1 = {C_MEM, 1'b0, 2'd1};
   localparam logic [11:0] X_MEM2 = {C_MEM, 1'b0, 2'd2};
   localparam logic [11:0] X_RUN2 = {C_RUN, 1'b0, 2'd2};
   localparam logic [11:0] X_BR2  = {C_BR, 1'b0, 2'd2};
   localparam logic [11:0] X_LU2  = {C_LU, 1'b0, 2'd2};
   localparam logic [11:0] X_ERR  = {9'd0, 1'b1, 2'd3};

   logic       clk_i;
   logic       reset_i;
   logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
   logic       id_uses_rs1_i, id_uses_rs2_i;
   logic       ex_mem_read_i, ex_branch_taken_i;
   logic       mem_req_i, mem_ready_i;
   logic       pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
   logic       ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
   logic       err_o;
   logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
`endif
   logic [11:0] obs;

   int  errors = 0;
   int  checks = 0;
   sb_t sb[$];

   pipeline_hazard_ctrl dut (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .id_rs1_i          (id_rs1_i),
      .id_rs2_i          (id_rs2_i),
      .id_uses_rs1_i     (id_uses_rs1_i),
      .id_uses_rs2_i     (id_uses_rs2_i),
      .ex_mem_read_i     (ex_mem_read_i),
      .ex_rd_i           (ex_rd_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .mem_req_i         (mem_req_i),
      .mem_ready_i       (mem_ready_i),
      .pc_en_o           (pc_en_o),
      .ifid_en_o         (ifid_en_o),
      .idex_en_o         (idex_en_o),
      .exmem_en_o        (exmem_en_o),
      .memwb_en_o        (memwb_en_o),
      .ifid_flush_o      (ifid_flush_o),
      .idex_flush_o      (idex_flush_o),
      .exmem_flush_o     (exmem_flush_o),
      .memwb_flush_o     (memwb_flush_o),
      .err_o             (err_o),
      .state_o           (state_o)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt_o       (stall_cnt_o),
      .flush_cnt_o       (flush_cnt_o)
`endif
   );

   assign obs = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
                 ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
                 err_o, state_o};

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic stim_t mk(input logic rst, input logic ld,
                                input logic [4:0] rd, input logic u1,
                                input logic [4:0] rs1, input logic u2,
                                input logic [4:0] rs2, input logic br,
                                input logic req, input logic rdy);
      stim_t s;
      s.rst = rst; s.ld = ld; s.rd = rd;
      s.u1 = u1; s.rs1 = rs1; s.u2 = u2; s.rs2 = rs2;
      s.br = br; s.req = req; s.rdy = rdy;
      return s;
   endfunction

   task automatic drive(input stim_t s, input logic [11:0] x, input int k);
      sb_t e;
      @(posedge clk_i);
      #1;
      reset_i           = s.rst;
      ex_mem_read_i     = s.ld;
      ex_rd_i           = s.rd;
      id_uses_rs1_i     = s.u1;
      id_rs1_i          = s.rs1;
      id_uses_rs2_i     = s.u2;
      id_rs2_i          = s.rs2;
      ex_branch_taken_i = s.br;
      mem_req_i         = s.req;
      mem_ready_i       = s.rdy;
      e.k = k;
      e.x = x;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      step_t t[6];
      sb_t   e;
      stim_t nop;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      t[0] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), X_INIT};
      for (int i = 1; i <= 4; i++) t[i] = '{nop, X_INIT};
      t[5] = '{nop, X_RUN};
      for (int i = 0; i < 6; i++) begin
         drive(t[i].s, t[i].x, i);
         @(negedge clk_i);
         e = sb.pop_front();
         checks++;
         if (obs !== e.x) begin
            errors++;
            $display("FAIL reset[%0d]: got %b want %b", e.k, obs, e.x);
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d/%0d want 0/0",
                  stall_cnt_o, flush_cnt_o);
      end
`endif
   endtask

   task automatic test_load_use();
      step_t t[6];
      sb_t   e;
      t[0] = '{mk(0, 1, 5, 0, 0, 1, 5, 0, 0, 0), X_LU};
      t[1] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), X_RUN};
      t[2] = '{mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0), X_RUN};
      t[3] = '{mk(0, 1, 7, 1, 7, 0, 0, 0, 0, 0), X_LU};
      t[4] = '{mk(0, 1, 7, 0, 7, 1, 3, 0, 0, 0), X_RUN};
      t[5] = '{mk(0, 0, 7, 1, 7, 0, 0, 0, 0, 0), X_RUN};
      for (int i = 0; i < 6; i++) begin
         drive(t[i].s, t[i].x, i);
         @(negedge clk_i);
         e = sb.pop_front();
         checks++;
         if (obs !== e.x) begin
            errors++;
            $display("FAIL load_use[%0d]: got %b want %b", e.k, obs, e.x);
         end
      end
   endtask

   task automatic test_branch();
      step_t t[3];
      sb_t   e;
      t[0] = '{mk(0, 1, 5, 0, 0, 1, 5, 1, 0, 0), X_BR};
      t[1] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), X_BR};
      t[2] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), X_RUN};
      for (int i = 0; i < 3; i++) begin
         drive(t[i].s, t[i].x, i);
         @(negedge clk_i);
         e = sb.pop_front();
         checks++;
         if (obs !== e.x) begin
            errors++;
            $display("FAIL branch[%0d]: got %b want %b", e.k, obs, e.x);
         end
      end
   endtask

   task automatic test_mem_stall();
      step_t t[13];
      sb_t   e;
      stim_t nop;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      t[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), X_MEM1};
      t[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), X_MEM2};
      t[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), X_MEM2};
      t[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), X_RUN2};
      t[4]  = '{nop, X_RUN};
      t[5]  = '{mk(0, 1, 5, 0, 0, 1, 5, 1, 1, 0), X_MEM1};
      t[6]  = '{mk(0, 1, 5, 0, 0, 1, 5, 1, 1, 0), X_MEM2};
      t[7]  = '{mk(0, 1, 5, 0, 0, 1, 5, 1, 0, 0), X_BR2};
      t[8]  = '{nop, X_RUN};
      t[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), X_RUN};
      t[10] = '{mk(0, 1, 9, 1, 9, 0, 0, 0, 1, 0), X_MEM1};
      t[11] = '{mk(0, 1, 9, 1, 9, 0, 0, 0, 1, 1), X_LU2};
      t[12] = '{nop, X_RUN};
      for (int i = 0; i < 13; i++) begin
         drive(t[i].s, t[i].x, i);
         @(negedge clk_i);
         e = sb.pop_front();
         checks++;
         if (obs !== e.x) begin
            errors++;
            $display("FAIL mem_stall[%0d]: got %b want %b", e.k, obs, e.x);
         end
      end
   endtask

   task automatic test_timeout();
      step_t t[24];
      sb_t   e;
      stim_t nop;
      stim_t stall;
      nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      stall = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      t[0] = '{stall, X_MEM1};
      for (int i = 1; i <= 15; i++) t[i] = '{stall, X_MEM2};
      t[16] = '{stall, X_ERR};
      t[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), X_ERR};
      t[18] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), X_ERR};
      for (int i = 19; i <= 22; i++) t[i] = '{nop, X_INIT};
      t[23] = '{nop, X_RUN};
      for (int i = 0; i < 24; i++) begin
         drive(t[i].s, t[i].x, i);
         @(negedge clk_i);
         e = sb.pop_front();
         checks++;
         if (obs !== e.x) begin
            errors++;
            $display("FAIL timeout[%0d]: got %b want %b", e.k, obs, e.x);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t t[9];
      sb_t   e;
      stim_t nop;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      t[0] = '{mk(0, 1, 12, 1, 12, 0, 0, 0, 0, 0), X_LU};
      t[1] = '{nop, X_RUN};
      t[2] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), X_MEM1};
      t[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), X_MEM2};
      t[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), X_MEM2};
      t[5] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), X_RUN2};
      t[6] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), X_BR};
      t[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), X_BR};
      t[8] = '{nop, X_RUN};
      for (int i = 0; i < 9; i++) begin
         drive(t[i].s, t[i].x, i);
         @(negedge clk_i);
         e = sb.pop_front();
         checks++;
         if (obs !== e.x) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got %b want %b",
                     e.k, obs, e.x);
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cnt_o !== 32'd4) begin
         errors++;
         $display("FAIL stall_cnt: got %0d want 4", stall_cnt_o);
      end
      checks++;
      if (flush_cnt_o !== 32'd2) begin
         errors++;
         $display("FAIL flush_cnt: got %0d want 2", flush_cnt_o);
      end
`endif
   endtask

   initial begin
      reset_i           = 1'b1;
      id_rs1_i          = '0;
      id_rs2_i          = '0;
      id_uses_rs1_i     = 1'b0;
      id_uses_rs2_i     = 1'b0;
      ex_mem_read_i     = 1'b0;
      ex_rd_i           = '0;
      ex_branch_taken_i = 1'b0;
      mem_req_i         = 1'b0;
      mem_ready_i       = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_stall();
      test_timeout();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d left want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
